effect_router: RTL

//  Next-generation effect controller: sequences each stereo sample pair through up to N_EFF

---
 rtl/effect_router.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/effect_router.sv
// effect_router: passes each stereo sample pair through up to N_EFF parallel
// effect slots (left channel, then right), sums the enabled slot results with
// saturation and presents the processed pair for I2S transmit. An empty slot
// selection bypasses the slots and returns the dry sample.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a sample strobe; latches dry samples and slot mask
//   SEND_L | offering the left dry sample to the slots
//   WAIT_L | collecting left results from the selected slots
//   SEND_R | offering the right dry sample to the slots
//   WAIT_R | collecting right results from the selected slots
//   MIX    | saturating both channel sums to the effect width
//   OUT    | updating the output registers and pulsing o_sample_valid
module effect_router #(
    parameter int D_WIDTH = 24,
    parameter int M_WIDTH = 16,
    parameter int N_EFF   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_sample_strobe,
    input  logic [D_WIDTH-1:0]       i_l_data,
    input  logic [D_WIDTH-1:0]       i_r_data,
    input  logic [N_EFF-1:0]         i_sel,
    output logic [M_WIDTH-1:0]       o_eff_data,
    output logic                     o_eff_chan,
    output logic                     o_eff_valid,
    input  logic                     i_eff_ready,
    input  logic [N_EFF*M_WIDTH-1:0] i_eff_data,
    input  logic [N_EFF-1:0]         i_eff_valid,
    output logic [D_WIDTH-1:0]       o_l_data,
    output logic [D_WIDTH-1:0]       o_r_data,
    output logic                     o_sample_valid,
    output logic                     o_timeout,
    output logic                     o_overrun
);

    // One guard bit beyond the worst-case sum of N_EFF full-scale results.
    localparam int ACC_W = M_WIDTH + $clog2(N_EFF) + 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SEND_L, WAIT_L, SEND_R, WAIT_R, MIX, OUT} state_t;

    state_t              state_q, state_d;
    logic [M_WIDTH-1:0]  dl_q, dl_d, dr_q, dr_d;
    logic [N_EFF-1:0]    sel_q, sel_d, got_q, got_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    res_l_q, res_l_d, res_r_q, res_r_d;
    logic [M_WIDTH-1:0]  sat_l_q, sat_l_d, sat_r_q, sat_r_d;
    logic                to_flag_q, to_flag_d;
    logic [D_WIDTH-1:0]  out_l_q, out_l_d, out_r_q, out_r_d;
    logic                valid_q, valid_d, timeout_q, timeout_d, overrun_q, overrun_d;

    logic [N_EFF-1:0]    new_bits, got_sum;
    logic [ACC_W-1:0]    acc_sum;
    logic                wait_done, wait_tmo;

    // The dry path only keeps the top M_WIDTH bits of each input sample.
    logic unused_lsb;
    assign unused_lsb = ^{i_l_data[D_WIDTH-M_WIDTH-1:0], i_r_data[D_WIDTH-M_WIDTH-1:0]};

    function automatic logic [ACC_W-1:0] sext(input logic [M_WIDTH-1:0] v);
        return {{(ACC_W-M_WIDTH){v[M_WIDTH-1]}}, v};
    endfunction

    // Clamp when the bits above the M_WIDTH sign bit disagree with the sum's sign.
    function automatic logic [M_WIDTH-1:0] sat(input logic [ACC_W-1:0] v);
        if (!v[ACC_W-1] && (|v[ACC_W-2:M_WIDTH-1]))
            return {1'b0, {(M_WIDTH-1){1'b1}}};
        else if (v[ACC_W-1] && !(&v[ACC_W-2:M_WIDTH-1]))
            return {1'b1, {(M_WIDTH-1){1'b0}}};
        else
            return v[M_WIDTH-1:0];
    endfunction

    // Accumulate first-arriving results of selected slots; repeats and unselected slots are ignored.
    always_comb begin
        new_bits = i_eff_valid & sel_q & ~got_q;
        got_sum  = got_q | new_bits;
        acc_sum  = acc_q;
        for (int k = 0; k < N_EFF; k++) begin
            if (new_bits[k])
                acc_sum = acc_sum + sext(i_eff_data[k*M_WIDTH +: M_WIDTH]);
        end
        wait_done = (got_sum == sel_q);
        wait_tmo  = (cnt_q == CNT_W'(1));
    end

    // Next-state and output decode for the sample sequencer.
    always_comb begin
        state_d     = state_q;
        dl_d        = dl_q;
        dr_d        = dr_q;
        sel_d       = sel_q;
        got_d       = got_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_l_d     = res_l_q;
        res_r_d     = res_r_q;
        sat_l_d     = sat_l_q;
        sat_r_d     = sat_r_q;
        to_flag_d   = to_flag_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        valid_d     = 1'b0;
        timeout_d   = 1'b0;
        overrun_d   = i_sample_strobe && (state_q != IDLE);
        o_eff_valid = 1'b0;
        o_eff_data  = '0;
        o_eff_chan  = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_sample_strobe) begin
                    dl_d      = i_l_data[D_WIDTH-1 -: M_WIDTH];
                    dr_d      = i_r_data[D_WIDTH-1 -: M_WIDTH];
                    sel_d     = i_sel;
                    to_flag_d = 1'b0;
                    if (i_sel == '0) begin
                        res_l_d = sext(i_l_data[D_WIDTH-1 -: M_WIDTH]);
                        res_r_d = sext(i_r_data[D_WIDTH-1 -: M_WIDTH]);
                        state_d = MIX;
                    end else begin
                        state_d = SEND_L;
                    end
                end
            end
            SEND_L, SEND_R: begin
                o_eff_valid = 1'b1;
                o_eff_chan  = (state_q == SEND_R);
                o_eff_data  = (state_q == SEND_R) ? dr_q : dl_q;
                if (i_eff_ready) begin
                    got_d   = '0;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(TIMEOUT);
                    state_d = (state_q == SEND_R) ? WAIT_R : WAIT_L;
                end
            end
            WAIT_L, WAIT_R: begin
                got_d = got_sum;
                acc_d = acc_sum;
                cnt_d = cnt_q - CNT_W'(1);
                if (wait_done || wait_tmo) begin
                    if (state_q == WAIT_L) begin
                        res_l_d = wait_done ? acc_sum : sext(dl_q);
                        state_d = SEND_R;
                    end else begin
                        res_r_d = wait_done ? acc_sum : sext(dr_q);
                        state_d = MIX;
                    end
                    if (!wait_done)
                        to_flag_d = 1'b1;
                end
            end
            MIX: begin
                sat_l_d = sat(res_l_q);
                sat_r_d = sat(res_r_q);
                state_d = OUT;
            end
            OUT: begin
                out_l_d   = {sat_l_q, {(D_WIDTH-M_WIDTH){1'b0}}};
                out_r_d   = {sat_r_q, {(D_WIDTH-M_WIDTH){1'b0}}};
                valid_d   = 1'b1;
                timeout_d = to_flag_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any sample in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dl_q      <= '0;
            dr_q      <= '0;
            sel_q     <= '0;
            got_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            res_l_q   <= '0;
            res_r_q   <= '0;
            sat_l_q   <= '0;
            sat_r_q   <= '0;
            to_flag_q <= 1'b0;
            out_l_q   <= '0;
            out_r_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dl_q      <= dl_d;
            dr_q      <= dr_d;
            sel_q     <= sel_d;
            got_q     <= got_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            res_l_q   <= res_l_d;
            res_r_q   <= res_r_d;
            sat_l_q   <= sat_l_d;
            sat_r_q   <= sat_r_d;
            to_flag_q <= to_flag_d;
            out_l_q   <= out_l_d;
            out_r_q   <= out_r_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_l_data       = out_l_q;
    assign o_r_data       = out_r_q;
    assign o_sample_valid = valid_q;
    assign o_timeout      = timeout_q;
    assign o_overrun      = overrun_q;

endmodule
